// File: rtl/ieee488_sd_arbiter.sv
// Round-robin arbiter merging up to four per-drive SD block-request ports onto
// one host block channel, one outstanding transfer at a time.
module ieee488_sd_arbiter #(
  parameter  int          DRIVES  = 2,
  parameter  logic [23:0] TIMEOUT = 24'd12000000,
  localparam int          NDR     = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*NDR-1:0]    drv_lba,
  input  logic [6*NDR-1:0]     drv_blk_cnt,
  input  logic [NDR-1:0]       drv_rd,
  input  logic [NDR-1:0]       drv_wr,
  output logic [NDR-1:0]       drv_ack,
  input  logic [8*NDR-1:0]     drv_buff_din,
  output logic [NDR-1:0]       drv_buff_wr,
  output logic [31:0]          host_lba,
  output logic [5:0]           host_blk_cnt,
  output logic                 host_rd,
  output logic                 host_wr,
  input  logic                 host_ack,
  input  logic                 host_buff_wr,
  output logic [7:0]           host_buff_din,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]     r_state;
  logic [1:0]     r_grant;
  logic [1:0]     r_last_grant;
  logic [23:0]    r_cnt;
  logic [NDR-1:0] r_drv_ack;
  logic           r_host_rd;
  logic           r_host_wr;
  logic [31:0]    r_host_lba;
  logic [5:0]     r_host_blk_cnt;
  logic           r_timeout_err;

  logic [NDR-1:0] w_pend;
  logic [1:0]     w_sel;
  logic           w_found;
  logic           w_sel_rd;
  logic           w_sel_wr;
  logic [31:0]    w_sel_lba;
  logic [5:0]     w_sel_blk;
  logic [NDR-1:0] w_grant_oh;
  logic [7:0]     w_buff_din;
  logic [NDR-1:0] w_buff_wr;

  assign w_pend = drv_rd | drv_wr;

  // Round-robin pick: first pending drive scanning upward from last_grant+1 with wrap.
  always_comb begin
    int idx;
    w_sel   = r_last_grant;
    w_found = 1'b0;
    for (int k = 1; k <= NDR; k++) begin
      idx = int'(r_last_grant) + k;
      idx = (idx >= NDR) ? (idx - NDR) : idx;
      for (int i = 0; i < NDR; i++) begin
        w_sel   = (!w_found && w_pend[i] && (idx == i)) ? 2'(i) : w_sel;
        w_found = w_found | (w_pend[i] && (idx == i));
      end
    end
  end

  // Request fields of the drive being selected, and per-drive decode of the current grant.
  always_comb begin
    w_sel_rd   = 1'b0;
    w_sel_wr   = 1'b0;
    w_sel_lba  = 32'd0;
    w_sel_blk  = 6'd0;
    w_buff_din = 8'd0;
    w_grant_oh = '0;
    w_buff_wr  = '0;
    for (int i = 0; i < NDR; i++) begin
      w_sel_rd      = (w_sel == 2'(i)) ? drv_rd[i] : w_sel_rd;
      w_sel_wr      = (w_sel == 2'(i)) ? drv_wr[i] : w_sel_wr;
      w_sel_lba     = (w_sel == 2'(i)) ? drv_lba[32*i +: 32] : w_sel_lba;
      w_sel_blk     = (w_sel == 2'(i)) ? drv_blk_cnt[6*i +: 6] : w_sel_blk;
      w_buff_din    = (r_grant == 2'(i)) ? drv_buff_din[8*i +: 8] : w_buff_din;
      w_grant_oh[i] = (r_grant == 2'(i));
      w_buff_wr[i]  = (r_grant == 2'(i)) && (r_state == S_XFER) && host_buff_wr;
    end
  end

  // Transfer FSM: grant, hold request until ack, track ack, release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_grant        <= 2'd0;
      r_last_grant   <= 2'(NDR - 1);
      r_cnt          <= 24'd0;
      r_drv_ack      <= '0;
      r_host_rd      <= 1'b0;
      r_host_wr      <= 1'b0;
      r_host_lba     <= 32'd0;
      r_host_blk_cnt <= 6'd0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 24'd0;
          if (w_found) begin
            r_grant        <= w_sel;
            r_host_lba     <= w_sel_lba;
            r_host_blk_cnt <= w_sel_blk;
            r_host_rd      <= w_sel_rd;
            r_host_wr      <= ~w_sel_rd & w_sel_wr;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (host_ack) begin
            r_host_rd <= 1'b0;
            r_host_wr <= 1'b0;
            r_drv_ack <= w_grant_oh;
            r_cnt     <= 24'd0;
            r_state   <= S_XFER;
          end else if (r_cnt == (TIMEOUT - 24'd1)) begin
            // Abort without acking the drive; its request stays up and is re-arbitrated.
            r_host_rd     <= 1'b0;
            r_host_wr     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_cnt         <= 24'd0;
            r_state       <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_XFER: begin
          if (!host_ack) begin
            r_drv_ack <= '0;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drv_ack       = r_drv_ack;
  assign drv_buff_wr   = w_buff_wr;
  assign host_lba      = r_host_lba;
  assign host_blk_cnt  = r_host_blk_cnt;
  assign host_rd       = r_host_rd;
  assign host_wr       = r_host_wr;
  assign host_buff_din = w_buff_din;
  assign grant         = r_grant;
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_timeout_err;

endmodule
